// File: rtl/mul8_share_sequencer.sv
// Two-requester front end that builds an unsigned 8x8 product from four passes
// through one external combinational 4x4 multiplier, then returns it tagged with the requester ID.
module mul8_share_sequencer #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic [3:0]  mul_m,
  output logic [3:0]  mul_q,
  input  logic [7:0]  mul_p,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [15:0] res_product,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        id_q, id_d;
  logic        last_grant_q, last_grant_d;
  logic        grant;
  logic        accept;
  logic [15:0] partial;

  // On a tie, fair mode hands the block to whoever did not win last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = FAIR ? ~last_grant_q : 1'b0;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    mul_m = 4'h0;
    mul_q = 4'h0;
    if (state_q == MUL) begin
      mul_m = step_q[1] ? a_q[7:4] : a_q[3:0];
      mul_q = step_q[0] ? b_q[7:4] : b_q[3:0];
    end
  end

  // Cross terms land at bit 4, the high-high term at bit 8.
  always_comb begin
    case (step_q)
      2'd0:    partial = {8'h00, mul_p};
      2'd3:    partial = {mul_p, 8'h00};
      default: partial = {4'h0, mul_p, 4'h0};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    acc_d        = acc_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d          = grant ? req1_a : req0_a;
          b_d          = grant ? req1_b : req0_b;
          id_d         = grant;
          last_grant_d = grant;
          acc_d        = 16'h0000;
          step_d       = 2'd0;
          state_d      = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_q + partial;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_q       <= 2'd0;
      acc_q        <= 16'h0000;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      acc_q        <= acc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid   = (state_q == DONE);
  assign res_product = res_valid ? acc_q : 16'h0000;
  assign res_id      = id_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mul8_share_sequencer.sv
// Bench for mul8_share_sequencer: directed scenarios plus random traffic, checked
// against a transaction-level model (grant rule, 5-cycle latency, a*b result).
module tb_mul8_share_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v0, v1, r0, r1, rv, rr, rid, bsy;
  logic [7:0]  a0, b0, a1, b1, mp;
  logic [3:0]  mm, mq;
  logic [15:0] rp;

  logic        f_v0, f_v1, f_r0, f_r1, f_rv, f_rr, f_rid, f_bsy;
  logic [7:0]  f_a0, f_b0, f_a1, f_b1, f_mp;
  logic [3:0]  f_mm, f_mq;
  logic [15:0] f_rp;

  assign mp   = {4'h0, mm} * {4'h0, mq};
  assign f_mp = {4'h0, f_mm} * {4'h0, f_mq};

  mul8_share_sequencer #(.FAIR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1),
    .mul_m(mm), .mul_q(mq), .mul_p(mp),
    .res_valid(rv), .res_ready(rr), .res_id(rid), .res_product(rp), .busy(bsy)
  );

  mul8_share_sequencer #(.FAIR(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_v0), .req0_ready(f_r0), .req0_a(f_a0), .req0_b(f_b0),
    .req1_valid(f_v1), .req1_ready(f_r1), .req1_a(f_a1), .req1_b(f_b1),
    .mul_m(f_mm), .mul_q(f_mq), .mul_p(f_mp),
    .res_valid(f_rv), .res_ready(f_rr), .res_id(f_rid), .res_product(f_rp), .busy(f_bsy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model of the FAIR=1 instance.
  bit          m_infl;
  int          m_age;
  bit          m_lg;
  bit          m_id;
  logic [7:0]  m_a, m_b;
  bit          grants[$];
  logic [15:0] prod_q[$];
  bit          id_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_infl = 1'b0;
    m_age  = 0;
    m_lg   = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_r0"}, r0, 0);   chk({tag, "_r1"}, r1, 0);
    chk({tag, "_rv"}, rv, 0);   chk({tag, "_rp"}, rp, 0);
    chk({tag, "_rid"}, rid, 0); chk({tag, "_busy"}, bsy, 0);
    chk({tag, "_mm"}, mm, 0);   chk({tag, "_mq"}, mq, 0);
  endtask

  // One clock of stimulus on the FAIR=1 instance, checked against the model.
  task automatic cycle(input bit iv0, input logic [7:0] ia0, input logic [7:0] ib0,
                       input bit iv1, input logic [7:0] ia1, input logic [7:0] ib1,
                       input bit irr);
    bit g, e0, e1, erv;
    int st;
    @(negedge clk);
    v0 = iv0; a0 = ia0; b0 = ib0;
    v1 = iv1; a1 = ia1; b1 = ib1;
    rr = irr;
    #1;
    g   = (iv0 && iv1) ? !m_lg : iv1;
    e0  = !m_infl && iv0 && !g;
    e1  = !m_infl && iv1 && g;
    erv = m_infl && (m_age >= 5);
    chk("req0_ready", r0, e0);
    chk("req1_ready", r1, e1);
    chk("res_valid", rv, erv);
    chk("busy", bsy, m_infl);
    if (erv) begin
      chk("res_product", rp, 16'(m_a) * 16'(m_b));
      chk("res_id", rid, m_id);
    end
    if (m_infl && m_age >= 1 && m_age <= 4) begin
      st = m_age - 1;
      chk("mul_m", mm, (st >= 2) ? m_a[7:4] : m_a[3:0]);
      chk("mul_q", mq, (st % 2 == 1) ? m_b[7:4] : m_b[3:0]);
    end else begin
      chk("mul_m_idle", mm, 0);
      chk("mul_q_idle", mq, 0);
    end
    if (e0 || e1) begin
      m_infl = 1'b1;
      m_age  = 1;
      m_id   = e1;
      m_lg   = e1;
      m_a    = e1 ? ia1 : ia0;
      m_b    = e1 ? ib1 : ib0;
      grants.push_back(e1);
    end else if (m_infl) begin
      if (erv && irr) begin
        m_infl = 1'b0;
        prod_q.push_back(rp);
        id_q.push_back(rid);
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 8'($urandom), 8'($urandom), 1'b0, 8'($urandom), 8'($urandom), 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int c0, c1;
    rst_n = 1'b0;
    v0 = 0; v1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; rr = 1;
    f_v0 = 0; f_v1 = 0; f_a0 = 0; f_b0 = 0; f_a1 = 0; f_b1 = 0; f_rr = 1;
    model_reset();
    do_reset();

    // Both requesters valid from reset, held continuously: 0,1,0,1.
    for (int i = 0; i < 24; i++) cycle(1'b1, 8'h0A, 8'h0B, 1'b1, 8'h10, 8'h10, 1'b1);
    idle(8);
    chk("fair_ngrants", grants.size(), 4);
    chk("fair_nres", prod_q.size(), 4);
    if (grants.size() >= 4 && prod_q.size() >= 4) begin
      chk("fair_g0", grants[0], 0); chk("fair_g1", grants[1], 1);
      chk("fair_g2", grants[2], 0); chk("fair_g3", grants[3], 1);
      chk("fair_p0", prod_q[0], 16'h006E); chk("fair_id0", id_q[0], 0);
      chk("fair_p1", prod_q[1], 16'h0100); chk("fair_id1", id_q[1], 1);
    end

    // Single requests with the documented values.
    cycle(1'b1, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b1);
    idle(6);
    chk("t1_prod", prod_q[$], 16'h03A8); chk("t1_id", id_q[$], 0);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b1);
    idle(6);
    chk("t2_prod", prod_q[$], 16'hFE01); chk("t2_id", id_q[$], 1);
    cycle(1'b1, 8'h00, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b1);
    idle(6);
    chk("t2_zero", prod_q[$], 16'h0000);

    // Consumer stalls 10 cycles while both requesters wait.
    cycle(1'b1, 8'hC3, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'($urandom), 8'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h21, 8'h43, 1'b1, 8'h65, 8'h87, 1'b0);
    cycle(1'b1, 8'h21, 8'h43, 1'b1, 8'h65, 8'h87, 1'b1);
    chk("stall_prod", prod_q[$], 16'hC3 * 16'h5A);
    cycle(1'b1, 8'h21, 8'h43, 1'b1, 8'h65, 8'h87, 1'b1);
    idle(6);

    // Asynchronous reset in the middle of MUL discards the operation.
    cycle(1'b1, 8'h77, 8'h99, 1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    c0 = prod_q.size();
    idle(4);
    cycle(1'b1, 8'h03, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1);
    idle(6);
    chk("rst_nres", prod_q.size(), c0 + 1);
    chk("rst_prod", prod_q[$], 16'h000F);
    chk("rst_id", id_q[$], 0);

    // Fixed-priority instance: requester 0 wins every time.
    c0 = 0; c1 = 0;
    @(negedge clk);
    f_v0 = 1; f_v1 = 1; f_a0 = 8'h0A; f_b0 = 8'h0B; f_a1 = 8'h10; f_b1 = 8'h10; f_rr = 1;
    for (int i = 0; i < 24; i++) begin
      #1;
      if (f_r0) c0++;
      if (f_r1) c1++;
      if (f_rv) begin
        chk("fp_prod", f_rp, 16'h006E);
        chk("fp_id", f_rid, 0);
      end
      @(negedge clk);
    end
    f_v0 = 0; f_v1 = 0;
    chk("fp_r0_accepts", c0, 4);
    chk("fp_r1_ready", c1, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(3, 0) != 0));
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul8_share_sequencer.md
Name: mul8_share_sequencer

Overview:
Sequences one shared 4x4 combinational array multiplier to compute unsigned 8x8 products over four passes.
Two requesters share the block through valid/ready handshakes, with round-robin or fixed-priority arbitration.
Results go out on a valid/ready result port tagged with the requester ID.
The block sits between requester logic and the single 4x4 multiplier instance, which is external and reached only through the mul_* ports.

Parameters:
FAIR, 1, 1 = round-robin between requesters on a tie; 0 = fixed priority, requester 0 always wins.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operand pair
req0_ready  output  1  requester 0 operands accepted this cycle
req0_a  input  8  requester 0 multiplicand
req0_b  input  8  requester 0 multiplier
req1_valid  input  1  requester 1 has an operand pair
req1_ready  output  1  requester 1 operands accepted this cycle
req1_a  input  8  requester 1 multiplicand
req1_b  input  8  requester 1 multiplier
mul_m  output  4  nibble to external 4x4 multiplier, m operand
mul_q  output  4  nibble to external 4x4 multiplier, q operand
mul_p  input  8  combinational product from external multiplier
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_id  output  1  requester that issued this result
res_product  output  16  unsigned a*b
busy  output  1  high in any state other than IDLE

Behaviour:
- Single clock; reset is asynchronous and active-low on rst_n.
- All flops clear on reset:
  - state = IDLE, step = 0, acc = 0, last_grant = 1 (so requester 0 wins the first tie).
  - Operand registers and res_id = 0.
- Reset outputs: req*_ready = 0, res_valid = 0, res_product = 0, res_id = 0, busy = 0, mul_m = mul_q = 0.
- States: IDLE -> MUL -> DONE -> IDLE.
- IDLE, arbitration (combinational):
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid, FAIR = 1: grant the requester that is not last_grant.
  - Both valid, FAIR = 0: grant 0.
  - reqN_ready = (state == IDLE) & reqN_valid & (grant == N).
  - At most one ready is high in any cycle. Ready is never high outside IDLE.
- Accept (cycle T, valid & ready):
  - Capture a, b and the ID; set last_grant = ID.
  - Clear acc; step = 0; state -> MUL.
- MUL, one pass per cycle (T+1..T+4), step 0..3:
  - step 0: mul_m = a[3:0], mul_q = b[3:0]; acc += mul_p.
  - step 1: mul_m = a[3:0], mul_q = b[7:4]; acc += mul_p << 4.
  - step 2: mul_m = a[7:4], mul_q = b[3:0]; acc += mul_p << 4.
  - step 3: mul_m = a[7:4], mul_q = b[7:4]; acc += mul_p << 8; state -> DONE.
  - mul_p is sampled in the same cycle mul_m/mul_q are driven (purely combinational multiplier, no wait state).
  - acc is 16 bits. The final sum cannot exceed 0xFE01, so there is no overflow; intermediate wrap is not possible.
- mul_m and mul_q are 0 in IDLE and DONE.
- DONE:
  - res_valid = 1; res_product = acc; res_id = captured ID.
  - All three hold stable until res_ready is high.
  - On res_valid & res_ready: state -> IDLE at the next edge, and res_valid drops.
  - No new request is accepted in the handshake cycle; ready reasserts the cycle after.
- Timing:
  - Accept at T gives res_valid at T+5 (latency 5).
  - Minimum request-to-request spacing is 6 cycles with res_ready held high.
- Requester valid deasserting while not granted: no effect; nothing is latched.
- Requester operands changing after accept: no effect; operands were captured at accept.
- Reset asserted mid-MUL or mid-DONE: the operation is discarded, nothing is output, and all outputs go to reset values immediately (asynchronous).
- busy = (state != IDLE).

Test Plan:
1. req0 a=0x12 b=0x34, res_ready=1 -> req0_ready at T; mul_m/mul_q sequence (2,4),(2,3),(1,4),(1,3) on T+1..T+4; res_valid at T+5 with res_product=0x03A8, res_id=0.
2. req1 a=0xFF b=0xFF -> res_product=0xFE01, res_id=1. Also a=0x00 b=0xA5 -> 0x0000.
3. req0 (0x0A,0x0B) and req1 (0x10,0x10) both valid from reset, FAIR=1:
   - Expect req0 served first, result 0x006E id 0, then req1, result 0x0100 id 1.
   - Repeat with both valid again: req0 is granted again, since last_grant=1 after serving req1.
   - Hold both valid continuously: grants alternate 0,1,0,1.
4. FAIR=0, both valid continuously -> req0 granted every time; req1_ready never high.
5. res_ready=0 for 10 cycles after res_valid:
   - res_valid, res_product and res_id stay stable; req0_ready and req1_ready stay 0; busy=1.
   - res_ready=1 -> IDLE next cycle; ready reasserts the cycle after the handshake.
6. rst_n low at T+2 during MUL:
   - All outputs at reset values immediately.
   - After release, a new request 0x03*0x05 completes with 0x000F and the stale operation never appears.
